cordic_vectoring_fixed: RTL and testbench
=========================================

# cordic_vectoring_fixed

Iterative fixed-point CORDIC in vectoring mode, the inverse of `cordic_rotation_fixed`. It drives an input vector (x, y) onto the positive x-axis and reports the gain-compensated magnitude and the angle atan2(y, x). In the matrix-inversion datapath it produces the Givens angle that `cordic_rotation_fixed` then applies to the remaining row elements. It performs one micro-rotation per clock and uses a valid/done handshake.

## Interface
- N, 15: number of micro-rotation iterations (i = 0..N-1).
- wordLength, 16: width of every I/O word.
- fractionLength, 12: fraction bits of every I/O word. Signed Qm.fractionLength; angles are in radians.
- clk  in  1  clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid  in  1  request; `x_in`/`y_in` are captured when it is accepted.
- x_in  in  wordLength  signed x component.
- y_in  in  wordLength  signed y component.
- x_out  out  wordLength  magnitude sqrt(x²+y²), gain-compensated, always ≥ 0.
- theta_out  out  wordLength  atan2(y_in, x_in), in [-π, +π].
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- busy  out  1  high from acceptance until `done`.

## Operation
- States: IDLE → PRE → ITER → SCALE → DONE.
- Acceptance: a request is accepted when `valid`=1 at an edge in IDLE or DONE.
  - On acceptance, sign-extend `x_in`/`y_in` into internal signed registers `x`, `y` of width 2*wordLength.
  - The internal format carries fractionLength+wordLength/2 fraction bits: shift the inputs left by wordLength/2.
  - Set z = 0 and move to PRE.
  - The bench probes `x` and `y` hierarchically, so those names are fixed.
- PRE (quadrant fold): if x < 0, set x ← −x, y ← −y, and z ← +PI when y ≥ 0, else −PI. Otherwise no change. Then move to ITER with i = 0.
- ITER (one iteration per edge), using simultaneous update from the pre-edge values and arithmetic shifts:
  - if y ≥ 0: x ← x + (y>>>i), y ← y − (x>>>i), z ← z + ATAN[i].
  - otherwise: x ← x − (y>>>i), y ← y + (x>>>i), z ← z − ATAN[i].
  - Leave ITER after i = N−1.
- Constants, in wordLength/fractionLength format:
  - ATAN[i] = round(atan(2^−i)·2^fractionLength), from a constant ROM.
  - PI = round(π·2^fractionLength), which is 12868 at the defaults.
  - K = round(0.6072529·2^fractionLength), which is 2487 at the defaults.
- SCALE:
  - Magnitude: x_out ← (x·K + rounding half-LSB) >>> (fractionLength + wordLength/2), saturated to 2^(wordLength−1)−1.
  - Angle: theta_out ← z. If z > PI, subtract 2·PI; if z < −PI, add 2·PI.
  - Move to DONE.
- DONE:
  - `done`=1 for exactly one cycle.
  - Leave to PRE if `valid`=1 (back-to-back request), else to IDLE.
- Output holding: `x_out` and `theta_out` hold their values until the next SCALE. They are not cleared on return to IDLE.
- Ignored requests: `valid` in PRE, ITER or SCALE is ignored. No queueing, no error.
- Zero input (x_in = y_in = 0): x_out = 0 and theta_out = 0 exactly, with no undefined behaviour.

## Timing
- Reset: at an edge with `rst`=1, the state becomes IDLE and i = 0. `x_out`, `theta_out`, `done` and `busy` are all 0; internal `x`, `y`, z are 0.
- Reset dominates `valid` in the same cycle.
- Reset mid-operation aborts the computation; `done` is not asserted for the aborted request.
- Latency, with acceptance at edge 0:
  - PRE completes at edge 1.
  - The iterations complete at edges 2..N+1.
  - SCALE completes at edge N+2.
  - `done` is high in the cycle after edge N+2 (17 clocks at N=15).
- `busy`: high the cycle after acceptance, low in the cycle `done` is high.
- Throughput: one result per N+3 clocks with `valid` held high.
- Accuracy: |error| ≤ 4 LSB on both outputs at the defaults.

## Test plan
- Reset, then x_in=0x1000, y_in=0, one-cycle valid → `done` 17 clocks later; x_out=0x1000±4, theta_out=0±4. Check the reset values of all outputs before the request.
- x_in=0x1000, y_in=0x1000 → x_out=5793 (0x16A1)±4, theta_out=3217 (π/4)±4.
- x_in=−0x1000, y_in=0x1000 → theta_out=9651 (3π/4)±4. Then x_in=−0x1000, y_in=0 → theta_out=±12868±4, inside [−PI, PI].
- x_in=0, y_in=−0x3000 → x_out=0x3000±4, theta_out=−6434 (−π/2)±4. Then x_in=0x7FFF, y_in=0x7FFF → x_out=0x7FFF (saturated), theta_out=3217±4.
- `valid` toggled during ITER → ignored; the original result is unchanged. `valid` held high → `done` every 18 clocks.
- `rst` asserted at iteration 5 → no `done`; outputs are 0. A new request after reset completes normally.

Source files
------------

// File: rtl/cordic_vectoring_fixed.sv
// Iterative CORDIC in vectoring mode: drives (x, y) onto the +x axis, returning
// the gain-compensated magnitude and atan2(y, x), one micro-rotation per clock.
module cordic_vectoring_fixed #(
    parameter int N              = 15,
    parameter int wordLength     = 16,
    parameter int fractionLength = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid,
    input  logic signed [wordLength-1:0] x_in,
    input  logic signed [wordLength-1:0] y_in,
    output logic signed [wordLength-1:0] x_out,
    output logic signed [wordLength-1:0] theta_out,
    output logic                         done,
    output logic                         busy
);

    localparam int W        = wordLength;
    localparam int XW       = 2 * W;
    localparam int ZW       = W + 2;
    localparam int PW       = 3 * W;
    localparam int HALF     = W / 2;
    localparam int FRAC_INT = fractionLength + HALF;
    localparam int IW       = (N > 1) ? $clog2(N) : 1;

    // Constants held with 28 fraction bits, rounded once to the I/O format.
    localparam longint PI_Q28 = 64'sd843314857;
    localparam longint K_Q28  = 64'sd163008209;

    function automatic longint requant(input longint v_q28);
        int sh;
        sh = 28 - fractionLength;
        if (sh > 0)
            return (v_q28 + (longint'(1) <<< (sh - 1))) >>> sh;
        return v_q28 <<< (-sh);
    endfunction

    // round(atan(2^-i) * 2^12); entries beyond i = 12 round to zero.
    function automatic longint atan_q12(input int idx);
        case (idx)
            0:       return 3217;
            1:       return 1899;
            2:       return 1003;
            3:       return 509;
            4:       return 256;
            5:       return 128;
            6:       return 64;
            7:       return 32;
            8:       return 16;
            9:       return 8;
            10:      return 4;
            11:      return 2;
            12:      return 1;
            default: return 0;
        endcase
    endfunction

    localparam logic signed [ZW-1:0] PI_Z       = ZW'(requant(PI_Q28));
    localparam logic signed [ZW-1:0] TWO_PI_Z   = ZW'(2 * requant(PI_Q28));
    localparam logic signed [PW-1:0] K_P        = PW'(requant(K_Q28));
    localparam logic signed [PW-1:0] MAG_MAX    = PW'((longint'(1) <<< (W - 1)) - 1);
    localparam logic signed [PW-1:0] ROUND_HALF = PW'(longint'(1) <<< (FRAC_INT - 1));

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ITER,
        SCALE,
        DONE
    } state_t;

    state_t state_reg, state_next;

    logic signed [XW-1:0] x, y;
    logic signed [ZW-1:0] z;
    logic [IW-1:0]        iter_reg;

    logic signed [ZW-1:0] atan_rom [N];
    logic signed [XW-1:0] x_shift, y_shift;
    logic signed [ZW-1:0] atan_cur;
    logic signed [PW-1:0] mag_prod, mag_round;
    logic signed [W-1:0]  mag_next, theta_next;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_atan
            assign atan_rom[gi] = ZW'(requant(atan_q12(gi) <<< 16));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        done       = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE:  if (valid) state_next = PRE;
            PRE: begin
                busy       = 1'b1;
                state_next = ITER;
            end
            ITER: begin
                busy = 1'b1;
                if (iter_reg == IW'(N - 1))
                    state_next = SCALE;
            end
            SCALE: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = valid ? PRE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        x_shift   = x >>> iter_reg;
        y_shift   = y >>> iter_reg;
        atan_cur  = atan_rom[iter_reg];
        mag_prod  = PW'(x) * K_P;
        mag_round = (mag_prod + ROUND_HALF) >>> FRAC_INT;

        if (mag_round > MAG_MAX)
            mag_next = W'(MAG_MAX);
        else if (mag_round[PW-1])
            mag_next = '0;
        else
            mag_next = W'(mag_round);

        // A zero vector never rotates, so z would hold the sum of every ATAN entry.
        if (x == '0 && y == '0)
            theta_next = '0;
        else if (z > PI_Z)
            theta_next = W'(z - TWO_PI_Z);
        else if (z < -PI_Z)
            theta_next = W'(z + TWO_PI_Z);
        else
            theta_next = W'(z);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            iter_reg  <= '0;
            x_out     <= '0;
            theta_out <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (valid) begin
                        x <= XW'(x_in) <<< HALF;
                        y <= XW'(y_in) <<< HALF;
                        z <= '0;
                    end
                end
                PRE: begin
                    // Fold left-half-plane vectors by pi so the iterations only
                    // have to cover (-pi/2, pi/2).
                    if (x[XW-1]) begin
                        x <= -x;
                        y <= -y;
                        z <= y[XW-1] ? -PI_Z : PI_Z;
                    end
                    iter_reg <= '0;
                end
                ITER: begin
                    if (!y[XW-1]) begin
                        x <= x + y_shift;
                        y <= y - x_shift;
                        z <= z + atan_cur;
                    end else begin
                        x <= x - y_shift;
                        y <= y + x_shift;
                        z <= z - atan_cur;
                    end
                    iter_reg <= iter_reg + IW'(1);
                end
                SCALE: begin
                    x_out     <= mag_next;
                    theta_out <= theta_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring_fixed.sv
// Bench for cordic_vectoring_fixed: ideal real-math model of magnitude/atan2 plus
// a transaction-level timing model, compared against the DUT on every cycle.
`timescale 1ns/1ps
module tb_cordic_vectoring_fixed;

    localparam int N      = 15;
    localparam int W      = 16;
    localparam int FL     = 12;
    localparam int LAT    = N + 2;
    localparam int PI_LSB = 12868;
    localparam int TOL    = 4;

    logic                clk   = 1'b0;
    logic                rst   = 1'b1;
    logic                valid = 1'b0;
    logic signed [W-1:0] x_in  = '0;
    logic signed [W-1:0] y_in  = '0;
    logic signed [W-1:0] x_out, theta_out;
    logic                done, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    cordic_vectoring_fixed #(.N(N), .wordLength(W), .fractionLength(FL)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .x_in     (x_in),
        .y_in     (y_in),
        .x_out    (x_out),
        .theta_out(theta_out),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_int(input string name, input logic signed [63:0] act,
                             input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input logic signed [63:0] act,
                             input longint exp, input longint tol);
        longint d;
        checks++;
        d = longint'(act) - exp;
        if ($isunknown(act) || d > tol || d < -tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    function automatic real ideal_mag_real(input int xv, input int yv);
        return $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
    endfunction

    function automatic int ideal_mag(input int xv, input int yv);
        int r;
        r = $rtoi(ideal_mag_real(xv, yv) + 0.5);
        return (r > 32767) ? 32767 : r;
    endfunction

    function automatic int ideal_theta(input int xv, input int yv);
        real t;
        if (xv == 0 && yv == 0) return 0;
        t = $atan2(real'(yv), real'(xv)) * real'(1 << FL);
        return (t >= 0.0) ? $rtoi(t + 0.5) : -$rtoi(-t + 0.5);
    endfunction

    // Transaction-level model: one accepted request yields a result LAT edges later.
    bit m_started = 0, m_busy = 0, m_done = 0;
    bit m_mag_exact = 1, m_theta_exact = 1;
    int m_cnt = 0, m_xout = 0, m_theta = 0, m_x = 0, m_y = 0, m_txn = 0;
    int p_x, p_y, p_mag, p_theta;
    bit p_mag_exact, p_theta_exact;

    always @(posedge clk) begin
        m_started = 1;
        if (rst) begin
            m_busy = 0; m_done = 0; m_cnt = 0;
            m_xout = 0; m_theta = 0; m_mag_exact = 1; m_theta_exact = 1;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 0; m_done = 1;
                    m_xout = p_mag; m_theta = p_theta;
                    m_mag_exact = p_mag_exact; m_theta_exact = p_theta_exact;
                    m_x = p_x; m_y = p_y;
                end
            end else if (valid) begin
                m_busy = 1; m_cnt = LAT;
                p_x = int'(x_in); p_y = int'(y_in);
                p_mag = ideal_mag(p_x, p_y);
                p_theta = ideal_theta(p_x, p_y);
                p_theta_exact = (p_x == 0 && p_y == 0);
                p_mag_exact = p_theta_exact || (ideal_mag_real(p_x, p_y) >= 33000.0);
            end
        end
    end

    always @(negedge clk) begin
        int diff;
        if (m_started) begin
            check_int("busy", busy, m_busy);
            check_int("done", done, m_done);
            if (m_mag_exact) check_int("x_out", x_out, m_xout);
            else             check_tol("x_out", x_out, m_xout, TOL);
            checks++;
            diff = int'(theta_out) - m_theta;
            if (diff > PI_LSB)  diff -= 2 * PI_LSB;
            if (diff < -PI_LSB) diff += 2 * PI_LSB;
            if ($isunknown(theta_out) || (m_theta_exact && diff != 0) || diff > TOL || diff < -TOL) begin
                errors++;
                $display("FAIL theta_out: got %0d, expected %0d", theta_out, m_theta);
            end
            checks++;
            if (int'(theta_out) > PI_LSB || int'(theta_out) < -PI_LSB) begin
                errors++;
                $display("FAIL theta_range: got %0d, required within +/-%0d", theta_out, PI_LSB);
            end
            if (m_done) begin
                m_txn++;
                $display("txn %0d: x_in=%0d y_in=%0d -> x_out=%0d theta_out=%0d (ideal %0d, %0d)",
                         m_txn, m_x, m_y, x_out, theta_out, m_xout, m_theta);
            end
        end
    end

    // Issue one request from idle; checks capture, quadrant fold and latency.
    task automatic request(input int xv, input int yv, input bit noisy, output int lat);
        int edges;
        bit seen;
        @(negedge clk);
        valid = 1'b1; x_in = W'(xv); y_in = W'(yv);
        @(posedge clk); #1;
        check_int("capture_x", dut.x, longint'(xv) * 256);
        check_int("capture_y", dut.y, longint'(yv) * 256);
        @(negedge clk);
        valid = 1'b0;
        @(posedge clk); #1;
        check_int("fold_x", dut.x, (xv < 0) ? -longint'(xv) * 256 : longint'(xv) * 256);
        check_int("fold_y", dut.y, (xv < 0) ? -longint'(yv) * 256 : longint'(yv) * 256);
        edges = 1; seen = 0; lat = -1;
        while (!seen && edges < 40) begin
            @(posedge clk); edges++;
            @(negedge clk);
            if (done) begin
                seen = 1; lat = edges;
            end else if (noisy && edges >= 4 && edges <= 8) begin
                valid = edges[0];
                x_in = W'($urandom_range(32767)); y_in = W'($urandom_range(32767));
            end else begin
                valid = 1'b0;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no done, required one within 40 clocks");
        end
        check_int("latency", lat, LAT);
    endtask

    initial begin
        int lat, xv, yv, n_done, t_first, t_prev, tries;
        int gaps[$];

        repeat (3) @(negedge clk);
        check_int("reset_x_out", x_out, 0);
        check_int("reset_theta", theta_out, 0);
        check_int("reset_done", done, 0);
        check_int("reset_busy", busy, 0);
        check_int("reset_x", dut.x, 0);
        check_int("reset_y", dut.y, 0);
        rst = 1'b0;

        check_int("model_mag_45", ideal_mag(4096, 4096), 5793);
        check_int("model_theta_45", ideal_theta(4096, 4096), 3217);
        check_int("model_theta_135", ideal_theta(-4096, 4096), 9651);
        check_int("model_theta_m90", ideal_theta(0, -12288), -6434);
        check_int("model_theta_180", ideal_theta(-4096, 0), 12868);

        request(4096, 0, 0, lat);
        check_tol("x_out_0deg", x_out, 4096, TOL);
        check_tol("theta_0deg", theta_out, 0, TOL);
        request(4096, 4096, 0, lat);
        check_tol("x_out_45deg", x_out, 5793, TOL);
        check_tol("theta_45deg", theta_out, 3217, TOL);
        request(-4096, 4096, 0, lat);
        check_tol("theta_135deg", theta_out, 9651, TOL);
        request(-4096, 0, 0, lat);
        check_tol("theta_180deg_abs", (theta_out < 0) ? -theta_out : theta_out, 12868, TOL);
        request(0, -12288, 0, lat);
        check_tol("x_out_m90deg", x_out, 12288, TOL);
        check_tol("theta_m90deg", theta_out, -6434, TOL);
        request(32767, 32767, 0, lat);
        check_int("x_out_saturated", x_out, 32767);
        check_tol("theta_sat", theta_out, 3217, TOL);
        request(0, 0, 0, lat);
        check_int("x_out_zero", x_out, 0);
        check_int("theta_zero", theta_out, 0);

        request(4096, 4096, 1, lat);
        check_tol("x_out_noisy", x_out, 5793, TOL);
        check_tol("theta_noisy", theta_out, 3217, TOL);

        // valid held high: back-to-back results
        @(negedge clk);
        valid = 1'b1; x_in = 16'sd4096; y_in = 16'sd2048;
        n_done = 0; t_prev = 0;
        for (int k = 0; k < 100 && n_done < 3; k++) begin
            @(negedge clk);
            if (done) begin
                if (n_done > 0) gaps.push_back(cyc - t_prev);
                t_prev = cyc; n_done++;
                if (n_done == 3) valid = 1'b0;
            end
        end
        valid = 1'b0;
        check_int("held_done_count", n_done, 3);
        while (gaps.size() < 2) gaps.push_back(-1);
        check_int("throughput_gap1", gaps[0], N + 3);
        check_int("throughput_gap2", gaps[1], N + 3);
        repeat (2) @(negedge clk);

        // reset during iteration 5
        @(negedge clk);
        valid = 1'b1; x_in = 16'sd4096; y_in = 16'sd2048;
        @(negedge clk);
        valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_int("abort_x_out", x_out, 0);
        check_int("abort_theta", theta_out, 0);
        check_int("abort_busy", busy, 0);
        check_int("abort_x", dut.x, 0);
        n_done = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check_int("abort_no_done", n_done, 0);
        request(-4096, -4096, 0, lat);
        check_tol("theta_after_abort", theta_out, -9651, TOL);

        for (int t = 0; t < 40; t++) begin
            tries = 0;
            do begin
                xv = int'($urandom_range(28000)) - 14000;
                yv = int'($urandom_range(28000)) - 14000;
                tries++;
            end while (ideal_mag_real(xv, yv) < 1024.0 && tries < 20);
            if (ideal_mag_real(xv, yv) < 1024.0) xv = 5000;
            request(xv, yv, ($urandom_range(3) == 0), lat);
            repeat ($urandom_range(3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got no end of stimulus, required completion within 200000 ns");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
